// File: rtl/sevseg_pkg.sv
// Shared constants, types and width helper for the seven-segment scan controller.
package sevseg_pkg;

    // Bit positions inside one digit's segment byte
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    typedef logic [7:0] seg_t;

    // Logical pattern for a dark digit (1 = lit, before polarity is applied)
    localparam seg_t SEG_BLANK = 8'h00;

    // Counter width for a 0..n-1 range, never narrower than one bit
    function automatic int unsigned cw(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/sevseg_slot_timer.sv
// Slot timer: counts cycles inside a digit slot and steps the digit index.
module sevseg_slot_timer
    import sevseg_pkg::*;
#(
    parameter int unsigned PERIOD = 50000,
    parameter int unsigned DIGITS = 4,
    parameter int unsigned CNT_W  = cw(PERIOD),
    parameter int unsigned IDX_W  = cw(DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] slot_cnt,
    output logic [IDX_W-1:0] digit_idx,
    output logic             slot_last,
    output logic             frame_last
);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;

    assign slot_last  = (slot_cnt_q == CNT_W'(PERIOD - 1));
    assign frame_last = slot_last && (digit_idx_q == IDX_W'(DIGITS - 1));
    assign slot_cnt   = slot_cnt_q;
    assign digit_idx  = digit_idx_q;

    // Next-state: wrap the slot counter, advance the digit on the last slot cycle
    always_comb begin
        slot_cnt_d  = slot_cnt_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        if (slot_last) begin
            slot_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == IDX_W'(DIGITS - 1)) ? '0 : digit_idx_q + IDX_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment driver: double-buffered data, PWM dimming, dead time.
module sevseg_scan_ctrl
    import sevseg_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SEG_W          = 8,
    parameter int unsigned PERIOD         = 50000,
    parameter int unsigned DEAD           = 16,
    parameter int unsigned BRIGHT_W       = 4,
    parameter bit          EN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIGITS*SEG_W-1:0] seg_data,
    input  logic [DIGITS-1:0]       blank_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic [DIGITS-1:0]       sevseg_en,
    output logic [SEG_W-1:0]        sevseg_out,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int unsigned CNT_W = cw(PERIOD);
    localparam int unsigned IDX_W = cw(DIGITS);

    // XOR masks turning logical (1 = active) values into pin levels
    localparam logic [DIGITS-1:0] EN_OFF  = {DIGITS{EN_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]  SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};

    logic [CNT_W-1:0] slot_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic             slot_last;
    logic             frame_last;

    sevseg_slot_timer #(
        .PERIOD (PERIOD),
        .DIGITS (DIGITS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .slot_cnt   (slot_cnt),
        .digit_idx  (digit_idx),
        .slot_last  (slot_last),
        .frame_last (frame_last)
    );

    logic [DIGITS-1:0][SEG_W-1:0] act_seg_q, act_seg_d;
    logic [DIGITS-1:0][SEG_W-1:0] pend_seg_q, pend_seg_d;
    logic [DIGITS-1:0]            act_blank_q, act_blank_d;
    logic [DIGITS-1:0]            pend_blank_q, pend_blank_d;
    logic                         pending_q, pending_d;
    logic [BRIGHT_W-1:0]          bright_q, bright_d;
    logic [DIGITS-1:0]            en_q, en_d;
    logic [SEG_W-1:0]             out_q, out_d;
    logic                         frame_edge_q, frame_edge_d;
    logic                         frame_done_q, frame_done_d;

    logic [BRIGHT_W-1:0]          phase;
    logic                         pwm_on;
    logic                         lit;

    // Double buffer: loads fill pending; the swap happens only at the frame boundary
    always_comb begin
        act_seg_d    = act_seg_q;
        act_blank_d  = act_blank_q;
        pend_seg_d   = pend_seg_q;
        pend_blank_d = pend_blank_q;
        pending_d    = pending_q;
        if (load) begin
            pend_seg_d   = seg_data;
            pend_blank_d = blank_mask;
            pending_d    = 1'b1;
        end
        if (frame_last) begin
            if (load) begin
                act_seg_d   = seg_data;
                act_blank_d = blank_mask;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                act_seg_d   = pend_seg_q;
                act_blank_d = pend_blank_q;
                pending_d   = 1'b0;
            end
        end
    end

    // Lit decision and registered pin drive; brightness changes only between slots
    always_comb begin
        bright_d = slot_last ? brightness : bright_q;
        phase    = BRIGHT_W'(32'(slot_cnt) - DEAD);
        pwm_on   = (phase < bright_q) || (bright_q == '1);
        lit      = (32'(slot_cnt) >= DEAD) && !act_blank_q[digit_idx] && pwm_on;
        en_d     = EN_OFF;
        out_d    = SEG_OFF;
        if (lit) begin
            en_d  = (DIGITS'(1) << digit_idx) ^ EN_OFF;
            out_d = act_seg_q[digit_idx] ^ SEG_OFF;
        end else begin
            out_d = SEG_W'(SEG_BLANK) ^ SEG_OFF;
        end
        // Two stages so the pulse lines up with digit 0's first output cycle
        frame_edge_d = frame_last;
        frame_done_d = frame_edge_q;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_seg_q    <= '0;
            act_blank_q  <= '0;
            pend_seg_q   <= '0;
            pend_blank_q <= '0;
            pending_q    <= 1'b0;
            bright_q     <= '1;
            en_q         <= EN_OFF;
            out_q        <= SEG_OFF;
            frame_edge_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            act_seg_q    <= act_seg_d;
            act_blank_q  <= act_blank_d;
            pend_seg_q   <= pend_seg_d;
            pend_blank_q <= pend_blank_d;
            pending_q    <= pending_d;
            bright_q     <= bright_d;
            en_q         <= en_d;
            out_q        <= out_d;
            frame_edge_q <= frame_edge_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sevseg_en  = en_q;
    assign sevseg_out = out_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Scoreboard bench for sevseg_scan_ctrl with PERIOD=8, DEAD=2, DIGITS=4, BRIGHT_W=2.
module tb_sevseg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] seg_data;
    logic [3:0]  blank_mask;
    logic [1:0]  brightness;
    logic        load;
    logic [3:0]  sevseg_en;
    logic [7:0]  sevseg_out;
    logic        frame_done;
    logic        pending;

    sevseg_scan_ctrl #(
        .DIGITS         (4),
        .SEG_W          (8),
        .PERIOD         (8),
        .DEAD           (2),
        .BRIGHT_W       (2),
        .EN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .blank_mask (blank_mask),
        .brightness (brightness),
        .load       (load),
        .sevseg_en  (sevseg_en),
        .sevseg_out (sevseg_out),
        .frame_done (frame_done),
        .pending    (pending)
    );

    typedef struct packed {
        logic [3:0] en;
        logic [7:0] out;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   streaming = 1'b0;

    // Active-low enable pattern for each digit, hand-written
    logic [3:0] en_on [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Lit slot cycles per brightness code (bit c = slot cycle c), hand-derived
    localparam logic [7:0] MASK_B3 = 8'b1111_1100;
    localparam logic [7:0] MASK_B1 = 8'b0100_0100;
    localparam logic [7:0] MASK_B0 = 8'b0000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue one full frame (4 digits x 8 cycles) of expected pin values
    task automatic push_frame(input logic [7:0] mask, input logic [3:0] blank, input logic [31:0] outs);
        exp_t e;
        logic lit;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 8; c++) begin
                lit   = mask[c] && !blank[d];
                e.en  = lit ? en_on[d] : 4'hF;
                e.out = lit ? outs[d*8 +: 8] : 8'hFF;
                e.fd  = (d == 0 && c == 0);
                q.push_back(e);
            end
        end
    endtask

    task automatic pulse_load(input logic [31:0] s, input logic [3:0] b);
        seg_data   = s;
        blank_mask = b;
        load       = 1'b1;
        @(posedge clk);
        #1 load    = 1'b0;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done) chk("frame_done_timeout", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (q.size() != 0) chk("scoreboard_drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Monitor: starts at a frame_done when expectations are queued, then checks every cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            streaming = 1'b0;
        end else begin
            if (!streaming && frame_done && q.size() != 0) streaming = 1'b1;
            if (streaming) begin
                e = q.pop_front();
                chk("sevseg_en", 32'(sevseg_en), 32'(e.en));
                chk("sevseg_out", 32'(sevseg_out), 32'(e.out));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
                if (q.size() == 0) streaming = 1'b0;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        seg_data   = '0;
        blank_mask = '0;
        brightness = 2'd3;
        @(negedge clk);
        chk("reset_en", 32'(sevseg_en), 32'hF);
        chk("reset_out", 32'(sevseg_out), 32'hFF);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: basic digits at full brightness
        pulse_load({8'h4F, 8'h5B, 8'h06, 8'h3F}, 4'b0000);
        chk("t1_pending_set", 32'(pending), 32'd1);
        push_frame(MASK_B3, 4'b0000, {8'hB0, 8'hA4, 8'hF9, 8'hC0});
        wait_empty();
        chk("t1_pending_clear", 32'(pending), 32'd0);

        // 2: brightness 1, then brightness 0
        brightness = 2'd1;
        wait_fd();
        @(posedge clk);
        #1 push_frame(MASK_B1, 4'b0000, {8'hB0, 8'hA4, 8'hF9, 8'hC0});
        wait_empty();
        brightness = 2'd0;
        wait_fd();
        @(posedge clk);
        #1 push_frame(MASK_B0, 4'b0000, {8'hB0, 8'hA4, 8'hF9, 8'hC0});
        wait_empty();

        // 3: mid-frame load waits for the boundary
        brightness = 2'd3;
        wait_fd();
        repeat (9) @(posedge clk);
        #1 pulse_load({8'h4F, 8'h5B, 8'h06, 8'h7F}, 4'b0000);
        chk("t3_pending_set", 32'(pending), 32'd1);
        repeat (10) @(posedge clk);
        #1 chk("t3_pending_held", 32'(pending), 32'd1);
        push_frame(MASK_B3, 4'b0000, {8'hB0, 8'hA4, 8'hF9, 8'h80});
        wait_empty();
        chk("t3_pending_clear", 32'(pending), 32'd0);

        // 4: load on the exact boundary cycle goes straight to active
        wait_fd();
        repeat (30) @(posedge clk);
        #1 pulse_load({8'h7F, 8'h07, 8'h7D, 8'h6D}, 4'b0000);
        chk("t4_pending_zero", 32'(pending), 32'd0);
        push_frame(MASK_B3, 4'b0000, {8'h80, 8'hF8, 8'h82, 8'h92});
        wait_empty();
        chk("t4_pending_after", 32'(pending), 32'd0);

        // 5: blank digit 2 only
        pulse_load({8'h7F, 8'h07, 8'h7D, 8'h6D}, 4'b0100);
        wait_fd();
        @(posedge clk);
        #1 push_frame(MASK_B3, 4'b0100, {8'h80, 8'hF8, 8'h82, 8'h92});
        wait_empty();

        // 6: reset during the digit 2 slot clears buffers and restores full brightness
        pulse_load({8'h3F, 8'h3F, 8'h3F, 8'h3F}, 4'b0001);
        brightness = 2'd0;
        repeat (16) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_en", 32'(sevseg_en), 32'hF);
        chk("t6_rst_out", 32'(sevseg_out), 32'hFF);
        chk("t6_rst_pending", 32'(pending), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk("t6_en", 32'(sevseg_en), (k >= 3 && k <= 8) ? 32'hE : 32'hF);
            chk("t6_out", 32'(sevseg_out), 32'hFF);
            chk("t6_frame_done", 32'(frame_done), 32'd0);
            chk("t6_pending", 32'(pending), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_ctrl.md
Name: sevseg_scan_ctrl

Overview:
- Parametrised time-multiplexed driver for N-digit common-anode/cathode seven-segment displays, with decimal point.
- Adds four features to the fixed 4-digit scanner: configurable digit count and scan period, per-digit blanking, PWM brightness, and inter-digit dead time (anti-ghosting).
- Display data is double-buffered and swapped only at frame boundaries, so the display never tears.
- Sits between the display-data producers (decoders, UI logic) and the board pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..16).
- SEG_W, 8, segment bits per digit: [6:0] = a..g, [7] = dp.
- PERIOD, 50000, clock cycles per digit slot (>= 2).
- DEAD, 16, blanked cycles at the start of each slot (0 <= DEAD < PERIOD).
- BRIGHT_W, 4, brightness field width.
- EN_ACTIVE_LOW, 1, 1 = a digit enable drives 0 when active.
- SEG_ACTIVE_LOW, 1, 1 = a lit segment drives 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- seg_data  in  DIGITS*SEG_W  logical segment data, 1 = lit; digit i = [i*SEG_W +: SEG_W].
- blank_mask  in  DIGITS  1 = digit i fully dark.
- brightness  in  BRIGHT_W  PWM duty code.
- load  in  1  single-cycle strobe; captures seg_data and blank_mask.
- sevseg_en  out  DIGITS  digit enables, polarity set by EN_ACTIVE_LOW.
- sevseg_out  out  SEG_W  segment drive, polarity set by SEG_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse at the start of each new frame.
- pending  out  1  captured data is waiting for the frame swap.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (immediate, async):
  - slot_cnt = 0, digit_idx = 0, pending = 0, frame_done = 0.
  - Active and pending buffers = all 0.
  - brightness_lat = all ones.
  - sevseg_en and sevseg_out = inactive levels.
- Reset mid-frame: abort immediately; the scan restarts at digit 0, slot cycle 0, after deassertion.
- Slot timer:
  - slot_cnt counts 0..PERIOD-1 and wraps.
  - At slot_cnt == PERIOD-1, digit_idx advances 0 -> 1 -> ... -> DIGITS-1 -> 0.
  - With DIGITS == 1, digit_idx stays 0.
- Frame boundary: the cycle where slot_cnt == PERIOD-1 and digit_idx == DIGITS-1.
- Brightness is sampled into brightness_lat at slot_cnt == PERIOD-1 and takes effect in the next slot. Changes never alter the current slot.
- PWM: phase = (slot_cnt - DEAD) mod 2^BRIGHT_W. pwm_on = (phase < brightness_lat) OR (brightness_lat == all ones).
  - brightness 0 means dark.
  - All ones means 100% of the non-dead window.
- Lit condition (cycle t) = slot_cnt >= DEAD AND !active_blank[digit_idx] AND pwm_on.
- Outputs (registered, 1-cycle latency from internal state at t):
  - Lit: only bit digit_idx of sevseg_en is active, and sevseg_out = active_seg[digit_idx] with polarity applied.
  - Not lit: all enables inactive and all segments inactive.
  - Segments are never driven while enables are off.
- Double buffer:
  - load captures seg_data and blank_mask into the pending buffer and sets pending.
  - Repeated loads overwrite the pending buffer; last one wins.
  - At the frame boundary, if pending == 1, pending is copied to active and pending is cleared.
  - If load coincides with the frame boundary, the incoming seg_data and blank_mask go straight to active and pending ends 0.
- frame_done: asserted for one cycle, the cycle after every frame boundary (aligned with the first output cycle of digit 0). It is asserted whether or not a swap occurred.
- Counter widths: $clog2(PERIOD) and $clog2(DIGITS) with minimum 1. No overflow is possible by construction.

Decomposition:
- Package sevseg_pkg:
  - Segment index constants (SEG_A..SEG_G, SEG_DP).
  - typedef seg_t = logic [7:0].
  - Function cw(n) returning max(1, $clog2(n)).
  - Blank pattern constant.
- One sub-module sevseg_slot_timer(PERIOD, DIGITS): outputs slot_cnt, digit_idx, slot_last and frame_last.
- The top level holds the buffers, PWM compare, polarity and output registers.

Test Plan:
Common setup: PERIOD=8, DEAD=2, DIGITS=4, BRIGHT_W=2, both polarities active-low.
1. Reset release, load digits 0x3F/0x06/0x5B/0x4F, brightness=3, blank=0 -> after the first frame_done, digit 0 slot shows en=1111 for 2 cycles, then en=1110 with out=0xC0 for 6 cycles. Digits 1..3 follow with en 1101/1011/0111 and out 0xF9/0xA4/0xB0.
2. brightness=1 -> in each slot, en is active only on slot cycles 2 and 6 (phase 0). brightness=0 -> en=1111 throughout.
3. load digit0=0x7F at the cycle-10 mid-frame point -> pending=1; digit 0 keeps the old value until the boundary. After frame_done, pending=0 and out=0x80 for digit 0.
4. load asserted exactly on the frame-boundary cycle -> the new data is shown in the very next digit 0 slot, and pending stays 0.
5. blank_mask=4'b0100 -> the digit 2 slot shows en=1111 and out=0xFF for all 8 cycles, with no other digit affected.
6. Assert rst during the digit 2 slot -> outputs go inactive immediately. After release, the scan restarts at digit 0 with brightness full and the buffers cleared (en active, out=0xFF).
